// File: rtl/stacking_logistic_n.sv
// ============================================================================
// stacking_logistic_n : N-input stacking meta-classifier, serial weighted vote
// sum minus bias, compared against a threshold to produce a +/-1 decision.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stacking_logistic_n #(
  parameter int N_IN  = 3,
  parameter int W_W   = 10,
  parameter int ACC_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [2*N_IN-1:0]     in_predict,
  input  logic [N_IN*W_W-1:0]   weight,
  input  logic [W_W-1:0]        bias,
  input  logic [W_W-1:0]        thred,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_predict,
  output logic [ACC_W-1:0]      out_score
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ACC     = 2'd1,
    S_CMP     = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [W_W-1:0] x);
    return {{(ACC_W - W_W){x[W_W-1]}}, x};
  endfunction

  state_t                   state_q, state_d;
  logic [N_IN-1:0]          captured_q, captured_d;
  logic [2*N_IN-1:0]        votes_q, votes_d;
  logic [N_IN*W_W-1:0]      w_sh_q, w_sh_d;
  logic [W_W-1:0]           thred_sh_q, thred_sh_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     out_valid_q, out_valid_d;
  logic [1:0]               out_predict_q, out_predict_d;
  logic [ACC_W-1:0]         out_score_q, out_score_d;

  logic [N_IN-1:0]          cap;
  logic [W_W-1:0]           w_sel;
  logic [1:0]               v_sel;
  logic signed [ACC_W-1:0]  term;

  assign in_ready    = (state_q == S_COLLECT) ? ~captured_q : '0;
  assign cap         = in_valid & in_ready;
  assign out_valid   = out_valid_q;
  assign out_predict = out_predict_q;
  assign out_score   = out_score_q;

  // Vote bit 0 marks a non-abstain; bit 1 then selects the sign.
  always_comb begin
    w_sel = '0;
    v_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_sel = w_sh_q[i*W_W +: W_W];
        v_sel = votes_q[2*i +: 2];
      end
    end
    if (!v_sel[0])     term = '0;
    else if (v_sel[1]) term = -sext(w_sel);
    else               term = sext(w_sel);
  end

  always_comb begin
    state_d       = state_q;
    captured_d    = captured_q;
    votes_d       = votes_q;
    w_sh_d        = w_sh_q;
    thred_sh_d    = thred_sh_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_predict_d = out_predict_q;
    out_score_d   = out_score_q;
    case (state_q)
      S_COLLECT: begin
        captured_d = captured_q | cap;
        for (int i = 0; i < N_IN; i++) begin
          if (cap[i]) votes_d[2*i +: 2] = in_predict[2*i +: 2];
        end
        if (&captured_d) begin
          w_sh_d     = weight;
          thred_sh_d = thred;
          acc_d      = -sext(bias);
          idx_d      = '0;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + term;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        out_score_d   = acc_q;
        out_predict_d = (acc_q > sext(thred_sh_q)) ? 2'b01 : 2'b11;
        out_valid_d   = 1'b1;
        state_d       = S_OUT;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          captured_d  = '0;
          state_d     = S_COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_COLLECT;
      captured_q    <= '0;
      votes_q       <= '0;
      w_sh_q        <= '0;
      thred_sh_q    <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_predict_q <= 2'b00;
      out_score_q   <= '0;
    end else begin
      state_q       <= state_d;
      captured_q    <= captured_d;
      votes_q       <= votes_d;
      w_sh_q        <= w_sh_d;
      thred_sh_q    <= thred_sh_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_predict_q <= out_predict_d;
      out_score_q   <= out_score_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stacking_logistic_n.sv
// ============================================================================
// tb_stacking_logistic_n : directed self-checking bench for stacking_logistic_n
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stacking_logistic_n;

  localparam int N_IN  = 3;
  localparam int W_W   = 10;
  localparam int ACC_W = 14;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N_IN-1:0]     in_valid = '0;
  logic [N_IN-1:0]     in_ready;
  logic [2*N_IN-1:0]   in_predict = '0;
  logic [N_IN*W_W-1:0] weight = '0;
  logic [W_W-1:0]      bias = '0;
  logic [W_W-1:0]      thred = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [1:0]          out_predict;
  logic [ACC_W-1:0]    out_score;

  int n_vec = 0;
  int n_bad = 0;

  stacking_logistic_n #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_predict(in_predict),
    .weight(weight), .bias(bias), .thred(thred),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_predict(out_predict), .out_score(out_score)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] enc(input int v);
    if (v > 0)      return 2'b01;
    else if (v < 0) return 2'b11;
    else            return 2'b00;
  endfunction

  task automatic set_cfg(input int w0, input int w1, input int w2,
                         input int b, input int t);
    weight = {W_W'(w2), W_W'(w1), W_W'(w0)};
    bias   = W_W'(b);
    thred  = W_W'(t);
  endtask

  // Called just after edge T; expects out_valid visible after edge T+4.
  task automatic wait_result(input string tag, input int exp_score, input int exp_pred);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_lat"}, n, N_IN + 1);
    check_eq({tag, "_score"}, int'($signed(out_score)), exp_score);
    check_eq({tag, "_pred"}, int'(out_predict), exp_pred);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_vld_drop"}, int'(out_valid), 0);
    check_eq({tag, "_rdy_back"}, int'(in_ready), 7);
  endtask

  task automatic txn(input string tag, input int v0, input int v1, input int v2,
                     input int exp_score, input int exp_pred);
    in_predict = {enc(v2), enc(v1), enc(v0)};
    in_valid   = 3'b111;
    step();
    in_valid   = 3'b000;
    wait_result(tag, exp_score, exp_pred);
    accept(tag);
  endtask

  initial begin
    // Mid-cycle reset with votes pending; nothing may be captured.
    #3 rst = 1'b1;
    in_valid   = 3'b111;
    in_predict = 6'b010101;
    step();
    check_eq("rst_vld", int'(out_valid), 0);
    check_eq("rst_pred", int'(out_predict), 0);
    check_eq("rst_score", int'(out_score), 0);
    in_valid = 3'b000;
    step();
    rst = 1'b0;
    step();
    check_eq("rst_rdy", int'(in_ready), 7);

    // Basic: 100 - 50 - 30 - 20 = 0
    set_cfg(100, -50, 30, 20, 0);
    txn("basic_t0", 1, 1, -1, 0, 3);
    set_cfg(100, -50, 30, 20, -1);
    txn("basic_tm1", 1, 1, -1, 0, 1);

    // Staggered with abstain and ignored repeat: 100 - 30 - 20 = 50
    set_cfg(100, -50, 30, 20, 0);
    for (int c = 0; c < 8; c++) begin
      in_valid   = 3'b000;
      in_predict = 6'b000000;
      if (c == 0) begin in_valid = 3'b001; in_predict = {2'b00, 2'b00, 2'b01}; end
      if (c == 3) begin in_valid = 3'b100; in_predict = {2'b11, 2'b00, 2'b00}; end
      if (c == 5) begin in_valid = 3'b001; in_predict = {2'b00, 2'b00, 2'b11}; end
      if (c == 7) begin in_valid = 3'b010; in_predict = {2'b00, 2'b00, 2'b00}; end
      step();
      if (c == 0) check_eq("stag_rdy_c1", int'(in_ready), 6);
      if (c == 3) check_eq("stag_rdy_c4", int'(in_ready), 2);
    end
    in_valid = 3'b000;
    wait_result("stag", 50, 1);
    accept("stag");

    // Extremes: -1536 - 511 = -2047 ; 1536 - 511 = 1025
    set_cfg(-512, -512, -512, 511, 0);
    txn("ext_pos", 1, 1, 1, -2047, 3);
    set_cfg(-512, -512, -512, 511, -512);
    txn("ext_t512", 1, 1, 1, -2047, 3);
    txn("ext_neg", -1, -1, -1, 1025, 1);

    // Backpressure + shadow: 100 + 50 + 30 - 20 = 160
    set_cfg(100, -50, 30, 20, 0);
    in_predict = {enc(1), enc(-1), enc(1)};
    in_valid   = 3'b111;
    step();
    in_valid   = 3'b000;
    set_cfg(-7, 300, -200, -400, 500);
    wait_result("bp", 160, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("bp_hold_vld", int'(out_valid), 1);
      check_eq("bp_hold_score", int'($signed(out_score)), 160);
      check_eq("bp_hold_pred", int'(out_predict), 1);
      check_eq("bp_hold_rdy", int'(in_ready), 0);
    end
    accept("bp");
    set_cfg(100, -50, 30, 20, 0);
    txn("bp_next", 1, 1, -1, 0, 3);

    // Reset during ACC aborts the transaction silently.
    in_predict = {enc(1), enc(1), enc(1)};
    in_valid   = 3'b111;
    step();
    in_valid   = 3'b000;
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("rstacc_vld", int'(out_valid), 0);
    check_eq("rstacc_score", int'(out_score), 0);
    step();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (out_valid) seen++;
      end
      check_eq("rstacc_no_vld", seen, 0);
    end
    check_eq("rstacc_rdy", int'(in_ready), 7);
    // -100 + 50 + 30 - 20 = -40 > -41
    set_cfg(100, -50, 30, 20, -41);
    txn("post_rst", -1, -1, 1, -40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/stacking_logistic_n.md
# stacking_logistic_n

Parametrised stacking meta-classifier: collects one ±1 vote from each of N_IN base classifiers, forms the weighted sum minus bias, and compares it against a threshold to emit a final ±1 decision. It sits after the base-learner blocks in the stacking pipeline. It generalises the fixed 3-input logistic stage with:
- configurable channel count and weight width;
- per-channel valid/ready capture;
- a serial multiply-free accumulator;
- a registered score output;
- output backpressure.

The block never halts simulation and returns to collection after each result.

## Interface
- N_IN, 3: number of base-classifier channels (≥1).
- W_W, 10: signed width of each weight, bias and thred.
- ACC_W, 14: signed accumulator/score width. Must satisfy ACC_W ≥ W_W + ceil(log2(N_IN+1)) + 1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  N_IN  per-channel vote valid.
- in_ready  out  N_IN  per-channel ready; high only in COLLECT for channels not yet captured.
- in_predict  in  2*N_IN  channel i at [2i+1:2i]. Encoding: 2'b01 = +1, 2'b11 = −1, 2'b00/2'b10 = abstain (0).
- weight  in  N_IN*W_W  signed weight i at [W_W*(i+1)-1:W_W*i].
- bias  in  W_W  signed bias.
- thred  in  W_W  signed threshold.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_predict  out  2  2'b01 = positive class, 2'b11 = negative class.
- out_score  out  ACC_W  signed weighted sum minus bias.

## Operation
- FSM states: COLLECT, ACC, CMP, OUT.
- COLLECT:
  - Channel i is captured at an edge where in_valid[i] && in_ready[i]. This latches its vote and sets captured[i].
  - Any number of channels may capture in the same cycle.
  - in_valid on an already-captured channel is ignored; the first vote wins.
- Edge T, the edge at which captured becomes all-ones:
  - weight, bias and thred are snapshotted into shadow registers.
  - acc ← −sext(bias).
  - idx ← 0; state → ACC.
- ACC, one channel per cycle:
  - acc ← acc + term(idx), where term = +sext(w_idx) for +1, −sext(w_idx) for −1, and 0 for abstain. No multiplier is used.
  - idx increments. After idx = N_IN−1 is added, state → CMP.
- CMP:
  - out_score ← acc.
  - out_predict ← 2'b01 if acc > sext(thred) (signed, strict), else 2'b11.
  - out_valid ← 1; state → OUT.
- OUT:
  - out_valid, out_predict and out_score hold stable until an edge with out_ready = 1.
  - At that edge: out_valid ← 0, captured ← 0, state → COLLECT.
- in_ready is 0 in ACC, CMP and OUT. Votes presented then are not captured and must be held by the source.
- Input changes after T do not affect the in-flight result, because of the shadow registers.
- Width rule: all arithmetic is signed at ACC_W and sign-extended; with legal ACC_W there is no overflow or wrap.

## Timing
- Reset (asynchronous, any state) forces:
  - state = COLLECT, captured = 0, idx = 0, acc = 0;
  - out_valid = 0, out_predict = 2'b00, out_score = 0;
  - in_ready = all-ones once rst deasserts.
  
  Reset mid-ACC/CMP/OUT aborts the result silently.
- Latency: out_valid rises at edge T+N_IN+1, so it is visible in the cycle after that edge.
- With out_ready held high, out_valid is a 1-cycle pulse. in_ready reasserts after edge T+N_IN+2, and the next capture can occur at edge T+N_IN+3.
- out_ready high before out_valid has no effect.
- N_IN = 1: ACC lasts exactly one cycle.

## Test plan
- Reset: assert rst mid-cycle → out_valid = 0, out_predict = 2'b00, out_score = 0, in_ready = 3'b111 immediately after release; no capture during rst.
- Basic (N_IN=3, W_W=10): weights 100, −50, 30; bias 20; thred 0; votes +1, +1, −1 in one cycle at edge T → out_valid at edge T+4, out_score = 0, out_predict = 2'b11. Same case with thred = −1 → 2'b01.
- Staggered votes with abstain:
  - ch0 at cycle 0, ch2 at cycle 3, ch1 = 2'b00 at cycle 7.
  - A repeated ch0 vote of −1 at cycle 5 is ignored.
  - Expected: score = w0 − w2 − bias; in_ready[0] low from cycle 1.
- Extremes: weights −512 ×3, votes +1 ×3, bias 511 → out_score = −2047, out_predict 2'b11. Repeat with thred = −512 to confirm signed compare; no wrap.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs stable, in_ready all 0. Changing weight/bias/thred during ACC leaves the result unchanged. Release out_ready → one accept, next transaction correct.
- Reset mid-ACC: assert rst at edge T+2 → no out_valid ever for that transaction; a clean transaction afterwards matches the model.
